// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronizes the
// column sense lines, debounces press and release, and reports one key at a time.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 20
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic [15:0] onehot,
    output logic        key_valid,
    output logic [3:0]  key_idx
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DEBW = $clog2(DEB_CNT + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEB_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        col_meta;
    logic [3:0]        col_s;
    logic [DIVW-1:0]   div_cnt;
    logic              tick;
    logic [DEBW-1:0]   deb_cnt;
    logic [DEBW-1:0]   deb_next;
    logic [DEBW-1:0]   deb_inc;
    logic [1:0]        cand_row;
    logic [1:0]        cand_row_next;
    logic [1:0]        cand_col;
    logic [1:0]        cand_col_next;
    logic              cand_down;
    logic [3:0]        row_n_next;
    logic [3:0]        row_rot;
    logic [15:0]       onehot_next;
    logic              key_valid_next;
    logic [3:0]        key_idx_next;

    // Lowest-index column that reads low; only meaningful when some bit is low.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        logic [1:0] r;
        if (!c[0]) begin
            r = 2'd0;
        end else if (!c[1]) begin
            r = 2'd1;
        end else if (!c[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rn);
        logic [1:0] r;
        case (rn)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign deb_inc   = deb_cnt + DEBW'(1);
    assign cand_down = ~col_s[cand_col];
    assign row_rot   = {row_n[2:0], row_n[3]};

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_s    <= col_meta;
        end
    end

    // Free-running scan divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIVW'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            deb_cnt   <= '0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            row_n     <= 4'b1110;
            onehot    <= 16'd0;
            key_valid <= 1'b0;
            key_idx   <= 4'd0;
        end else begin
            state     <= state_next;
            deb_cnt   <= deb_next;
            cand_row  <= cand_row_next;
            cand_col  <= cand_col_next;
            row_n     <= row_n_next;
            onehot    <= onehot_next;
            key_valid <= key_valid_next;
            key_idx   <= key_idx_next;
        end
    end

    // Next-state logic; every transition is qualified by tick.
    always_comb begin
        state_next     = state;
        deb_next       = deb_cnt;
        cand_row_next  = cand_row;
        cand_col_next  = cand_col;
        row_n_next     = row_n;
        onehot_next    = onehot;
        key_valid_next = 1'b0;
        key_idx_next   = key_idx;
        case (state)
            SCAN: begin
                if (tick && (col_s == 4'hF)) begin
                    row_n_next = row_rot;
                end else if (tick) begin
                    cand_row_next = row_index(row_n);
                    cand_col_next = first_low(col_s);
                    deb_next      = '0;
                    state_next    = DEBOUNCE;
                end else begin
                    state_next = SCAN;
                end
            end
            DEBOUNCE: begin
                if (tick && cand_down && (deb_inc == DEB_LAST)) begin
                    deb_next       = deb_inc;
                    state_next     = PRESSED;
                    onehot_next    = 16'd1 << {cand_row, cand_col};
                    key_idx_next   = {cand_row, cand_col};
                    key_valid_next = 1'b1;
                end else if (tick && cand_down) begin
                    deb_next = deb_inc;
                end else if (tick) begin
                    state_next = SCAN;
                    row_n_next = row_rot;
                end else begin
                    state_next = DEBOUNCE;
                end
            end
            PRESSED: begin
                // Row stays held so only the candidate column is watched.
                if (tick && !cand_down) begin
                    state_next = RELEASE;
                    deb_next   = '0;
                end else begin
                    state_next = PRESSED;
                end
            end
            RELEASE: begin
                if (tick && !cand_down && (deb_inc == DEB_LAST)) begin
                    deb_next    = '0;
                    state_next  = SCAN;
                    onehot_next = 16'd0;
                    row_n_next  = row_rot;
                end else if (tick && !cand_down) begin
                    deb_next = deb_inc;
                end else if (tick) begin
                    state_next = PRESSED;
                end else begin
                    state_next = RELEASE;
                end
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEB_CNT=3) with a
// behavioural 4x4 key matrix driving col_n from row_n.
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] onehot;
    logic        key_valid;
    logic [3:0]  key_idx;
    logic [15:0] keys;

    int passed;
    int total;
    int kv_count;
    int kv_base;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_idx   (key_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid) kv_count <= kv_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_kv(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_clear(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (onehot !== 16'd0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {16'd0, onehot}, 32'd0);
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        kv_count = 0;
        keys     = 16'd0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_row_n", {28'd0, row_n}, 32'hE);
        chk("rst_onehot", {16'd0, onehot}, 32'd0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_key_idx", {28'd0, key_idx}, 32'd0);
        rst = 1'b0;

        // Idle scan: row index after edge k is (k/4)%4.
        for (int k = 1; k <= 40; k++) begin
            logic [3:0] exp_row;
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk("idle_row_n", {28'd0, row_n}, {28'd0, exp_row});
            chk("idle_onehot", {16'd0, onehot}, 32'd0);
            chk("idle_key_valid", {31'd0, key_valid}, 32'd0);
        end

        // Clean press of row 2 / col 1: row 2 already active, pulse 16 edges later.
        keys = 16'h0200;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("press_key_valid", {31'd0, key_valid}, (k == 16) ? 32'd1 : 32'd0);
            if (k == 16) begin
                chk("press_onehot", {16'd0, onehot}, 32'h0200);
                chk("press_key_idx", {28'd0, key_idx}, 32'd9);
            end
        end
        for (int k = 18; k <= 40; k++) begin
            @(negedge clk);
            chk("hold_row_n", {28'd0, row_n}, 32'hB);
            chk("hold_onehot", {16'd0, onehot}, 32'h0200);
        end
        chk("press_kv_count", kv_count, 32'd1);
        keys = 16'd0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            chk("release_onehot", {16'd0, onehot}, (j == 16) ? 32'd0 : 32'h0200);
        end
        chk("release_row_n", {28'd0, row_n}, 32'h7);
        chk("release_key_idx", {28'd0, key_idx}, 32'd9);

        // Glitch: key low for a single tick while row 2 is scanned.
        kv_base = kv_count;
        repeat (12) @(negedge clk);
        chk("glitch_row_pre", {28'd0, row_n}, 32'hB);
        keys = 16'h0200;
        repeat (4) @(negedge clk);
        chk("glitch_row_held", {28'd0, row_n}, 32'hB);
        keys = 16'd0;
        repeat (4) @(negedge clk);
        chk("glitch_row_adv", {28'd0, row_n}, 32'h7);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("glitch_onehot", {16'd0, onehot}, 32'd0);
        end
        chk("glitch_kv_count", kv_count - kv_base, 32'd0);

        // Release bounce: up 1 tick, down again, then up for good.
        kv_base = kv_count;
        keys = 16'h0200;
        wait_kv(200, "bounce_kv_seen");
        chk("bounce_onehot_pressed", {16'd0, onehot}, 32'h0200);
        keys = 16'd0;
        repeat (4) @(negedge clk);
        chk("bounce_onehot_rel1", {16'd0, onehot}, 32'h0200);
        chk("bounce_kv_rel1", {31'd0, key_valid}, 32'd0);
        keys = 16'h0200;
        repeat (4) @(negedge clk);
        chk("bounce_onehot_repress", {16'd0, onehot}, 32'h0200);
        chk("bounce_kv_repress", {31'd0, key_valid}, 32'd0);
        keys = 16'd0;
        repeat (15) @(negedge clk);
        chk("bounce_onehot_late", {16'd0, onehot}, 32'h0200);
        @(negedge clk);
        chk("bounce_onehot_clear", {16'd0, onehot}, 32'd0);
        chk("bounce_kv_count", kv_count - kv_base, 32'd1);

        // Two keys on row 0: col 0 wins, col 3 reported only after col 0 releases.
        kv_base = kv_count;
        keys = 16'h0009;
        wait_kv(200, "two_kv_first");
        chk("two_onehot_first", {16'd0, onehot}, 32'h0001);
        chk("two_key_idx_first", {28'd0, key_idx}, 32'd0);
        keys = 16'h0008;
        wait_clear(60, "two_clear");
        chk("two_row_adv", {28'd0, row_n}, 32'hD);
        chk("two_kv_count_mid", kv_count - kv_base, 32'd1);
        wait_kv(200, "two_kv_second");
        chk("two_onehot_second", {16'd0, onehot}, 32'h0008);
        chk("two_key_idx_second", {28'd0, key_idx}, 32'd3);
        @(negedge clk);
        chk("two_kv_count_end", kv_count - kv_base, 32'd2);
        keys = 16'd0;
        wait_clear(60, "two_final_clear");

        // Reset while a key is held in PRESSED.
        keys = 16'h0200;
        wait_kv(200, "rstp_kv_seen");
        chk("rstp_onehot_before", {16'd0, onehot}, 32'h0200);
        #2;
        rst = 1'b1;
        #1;
        chk("rstp_onehot", {16'd0, onehot}, 32'd0);
        chk("rstp_row_n", {28'd0, row_n}, 32'hE);
        chk("rstp_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rstp_key_idx", {28'd0, key_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk("rstp_key_valid_seq", {31'd0, key_valid}, (k == 24) ? 32'd1 : 32'd0);
            if (k == 3) chk("rstp_row0", {28'd0, row_n}, 32'hE);
            if (k == 4) chk("rstp_row1", {28'd0, row_n}, 32'hD);
            if (k == 8) chk("rstp_row2", {28'd0, row_n}, 32'hB);
        end
        chk("rstp_onehot_after", {16'd0, onehot}, 32'h0200);
        chk("rstp_key_idx_after", {28'd0, key_idx}, 32'd9);
        chk("rstp_row_held", {28'd0, row_n}, 32'hB);
        keys = 16'd0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
